// File: rtl/aether_cmd_sequencer_pkg.sv
// Shared aether constants: engine opcodes, register map, field widths and the
// command sequencer state encoding.
package aether_cmd_sequencer_pkg;

  localparam int unsigned INSTR_W  = 4;
  localparam int unsigned PARAM1_W = 4;
  localparam int unsigned PARAM2_W = 16;

  localparam logic [INSTR_W-1:0]  OP_NOP    = 4'h0;
  localparam logic [INSTR_W-1:0]  OP_RDR    = 4'h2;
  localparam logic [PARAM1_W-1:0] REG_STATS = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_IRQ,
    ST_CLEAR,
    ST_ERROR
  } seq_state_e;

endpackage

// File: rtl/aether_cmd_fifo.sv
// Command queue for the aether sequencer: power-of-two depth, wrapping pointers,
// explicit occupancy counter and a synchronous flush.
module aether_cmd_fifo #(
  parameter int unsigned Width = 25,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [Width-1:0]       data_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned LevelWidth = PtrWidth + 1;

  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wrPtr_q;
  logic [PtrWidth-1:0]   rdPtr_q;
  logic [LevelWidth-1:0] level_q;
  logic                  doPush;
  logic                  doPop;

  assign full_o  = (level_q == LevelWidth'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rdPtr_q];

  // Guard internally so a misbehaving caller can never corrupt the occupancy count.
  assign doPush = push_i & ~full_o & ~flush_i;
  assign doPop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PtrWidth'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PtrWidth'(1);
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + LevelWidth'(1);
        2'b01:   level_q <= level_q - LevelWidth'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/aether_cmd_sequencer.sv
// Queues engine commands and issues them one per cycle; wait entries stall the
// queue until an engine interrupt edge, then a stats-register read clears it.
module aether_cmd_sequencer
  import aether_cmd_sequencer_pkg::*;
#(
  parameter int unsigned InstrWidth    = INSTR_W,
  parameter int unsigned Param1Width   = PARAM1_W,
  parameter int unsigned Param2Width   = PARAM2_W,
  parameter int unsigned Depth         = 16,
  parameter int unsigned TimeoutCycles = 1_048_576
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        push_i,
  input  logic [InstrWidth+Param1Width+Param2Width-1:0] push_cmd_i,
  input  logic                                        push_wait_i,
  output logic                                        ready_o,
  input  logic                                        abort_i,
  input  logic                                        interrupt_i,
  output logic [InstrWidth-1:0]                       instruction_o,
  output logic [Param1Width-1:0]                      param_1_o,
  output logic [Param2Width-1:0]                      param_2_o,
  output logic                                        busy_o,
  output logic [$clog2(Depth):0]                      level_o,
  output logic                                        overflow_o,
  output logic                                        timeout_o
);

  localparam int unsigned CmdWidth   = InstrWidth + Param1Width + Param2Width;
  localparam int unsigned EntryWidth = CmdWidth + 1;
  localparam int unsigned CntWidth   = $clog2(TimeoutCycles + 1);

  seq_state_e               state_q, state_d;
  logic [InstrWidth-1:0]    instr_q, instr_d;
  logic [Param1Width-1:0]   param1_q, param1_d;
  logic [Param2Width-1:0]   param2_q, param2_d;
  logic                     isWait_q, isWait_d;
  logic [CntWidth-1:0]      waitCnt_q, waitCnt_d;
  logic                     overflow_q, overflow_d;
  logic                     timeout_q, timeout_d;
  logic                     irqPrev_q;

  logic                     fifoPush;
  logic                     fifoPop;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic [EntryWidth-1:0]    fifoHead;
  logic                     tryIssue;
  logic                     irqRise;

  // Aborting flushes the queue that same edge, so a concurrent push must not land.
  assign fifoPush = push_i & ~fifoFull & ~abort_i;
  assign irqRise  = interrupt_i & ~irqPrev_q;

  aether_cmd_fifo #(
    .Width (EntryWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (abort_i),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .data_i  ({push_wait_i, push_cmd_i}),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      instr_q    <= InstrWidth'(OP_NOP);
      param1_q   <= '0;
      param2_q   <= '0;
      isWait_q   <= 1'b0;
      waitCnt_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      irqPrev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      param1_q   <= param1_d;
      param2_q   <= param2_d;
      isWait_q   <= isWait_d;
      waitCnt_q  <= waitCnt_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      irqPrev_q  <= interrupt_i;
    end
  end

  // The registered command reflects what the engine sees in the state being entered.
  always_comb begin
    state_d    = state_q;
    instr_d    = InstrWidth'(OP_NOP);
    param1_d   = '0;
    param2_d   = '0;
    isWait_d   = 1'b0;
    waitCnt_d  = '0;
    overflow_d = overflow_q | (push_i & fifoFull);
    timeout_d  = timeout_q;
    fifoPop    = 1'b0;
    tryIssue   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_CLEAR: tryIssue = 1'b1;
      ST_ISSUE: begin
        if (isWait_q) state_d = ST_WAIT_IRQ;
        else          tryIssue = 1'b1;
      end
      ST_WAIT_IRQ: begin
        waitCnt_d = waitCnt_q + CntWidth'(1);
        if (irqRise) begin
          state_d  = ST_CLEAR;
          instr_d  = InstrWidth'(OP_RDR);
          param1_d = Param1Width'(REG_STATS);
        end else if (waitCnt_q == CntWidth'(TimeoutCycles - 1)) begin
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase

    if (tryIssue) begin
      if (!fifoEmpty) begin
        fifoPop = 1'b1;
        state_d = ST_ISSUE;
        {isWait_d, instr_d, param1_d, param2_d} = fifoHead;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (abort_i) begin
      state_d    = ST_IDLE;
      instr_d    = InstrWidth'(OP_NOP);
      param1_d   = '0;
      param2_d   = '0;
      isWait_d   = 1'b0;
      waitCnt_d  = '0;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
      fifoPop    = 1'b0;
    end
  end

  assign ready_o       = ~fifoFull;
  assign busy_o        = (state_q != ST_IDLE) | ~fifoEmpty;
  assign instruction_o = instr_q;
  assign param_1_o     = param1_q;
  assign param_2_o     = param2_q;
  assign overflow_o    = overflow_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_aether_cmd_sequencer.sv
// Directed bench for aether_cmd_sequencer (Depth=4, TimeoutCycles=64): latency,
// back-to-back issue, interrupt waits, timeout, overflow, abort and reset.
module tb_aether_cmd_sequencer;

  localparam int unsigned Depth         = 4;
  localparam int unsigned TimeoutCycles = 64;
  localparam logic [23:0] NOP_CMD = 24'h0_0_0000;
  localparam logic [23:0] RDR_CMD = 24'h2_A_0000;

  logic        clk_i;
  logic        rst_ni;
  logic        push_i;
  logic [23:0] push_cmd_i;
  logic        push_wait_i;
  logic        ready_o;
  logic        abort_i;
  logic        interrupt_i;
  logic [3:0]  instruction_o;
  logic [3:0]  param_1_o;
  logic [15:0] param_2_o;
  logic        busy_o;
  logic [2:0]  level_o;
  logic        overflow_o;
  logic        timeout_o;
  logic [23:0] outCmd;

  int checks   = 0;
  int failures = 0;

  assign outCmd = {instruction_o, param_1_o, param_2_o};

  aether_cmd_sequencer #(
    .Depth         (Depth),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push_i),
    .push_cmd_i    (push_cmd_i),
    .push_wait_i   (push_wait_i),
    .ready_o       (ready_o),
    .abort_i       (abort_i),
    .interrupt_i   (interrupt_i),
    .instruction_o (instruction_o),
    .param_1_o     (param_1_o),
    .param_2_o     (param_2_o),
    .busy_o        (busy_o),
    .level_o       (level_o),
    .overflow_o    (overflow_o),
    .timeout_o     (timeout_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Each call lands 1ns after a rising edge: that instant is the start of the next cycle.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    push_i      = 1'b0;
    push_cmd_i  = '0;
    push_wait_i = 1'b0;
    abort_i     = 1'b0;
    interrupt_i = 1'b0;
    #2;
    checks++;
    if (outCmd !== NOP_CMD) begin
      failures++;
      $display("[TB] FAIL reset_cmd got=%h exp=%h", outCmd, NOP_CMD);
    end
    checks++;
    if ({ready_o, busy_o, overflow_o, timeout_o} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_flags {ready,busy,ovf,tmo} got=%b exp=1000",
               {ready_o, busy_o, overflow_o, timeout_o});
    end
    checks++;
    if (level_o !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_level got=%0d exp=0", level_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();
    checks++;
    if ({outCmd, busy_o} !== {NOP_CMD, 1'b0}) begin
      failures++;
      $display("[TB] FAIL post_reset_idle cmd/busy got=%h/%b exp=%h/0", outCmd, busy_o, NOP_CMD);
    end
  endtask

  task automatic test_back_to_back();
    push_i = 1'b1; push_wait_i = 1'b0; push_cmd_i = 24'h5_1_0040;   // cycle 0
    step(); push_cmd_i = 24'h5_2_0004;                               // cycle 1
    checks++;
    if (outCmd !== NOP_CMD) begin
      failures++;
      $display("[TB] FAIL b2b_cyc1_cmd got=%h exp=%h", outCmd, NOP_CMD);
    end
    checks++;
    if (level_o !== 3'd1) begin
      failures++;
      $display("[TB] FAIL b2b_cyc1_level got=%0d exp=1", level_o);
    end
    step(); push_cmd_i = 24'h6_0_0000;                               // cycle 2
    checks++;
    if (outCmd !== 24'h5_1_0040) begin
      failures++;
      $display("[TB] FAIL b2b_cyc2_cmd got=%h exp=510040", outCmd);
    end
    checks++;
    if (level_o !== 3'd1) begin
      failures++;
      $display("[TB] FAIL b2b_cyc2_level_pushpop got=%0d exp=1", level_o);
    end
    step(); push_i = 1'b0;                                           // cycle 3
    checks++;
    if (outCmd !== 24'h5_2_0004) begin
      failures++;
      $display("[TB] FAIL b2b_cyc3_cmd got=%h exp=520004", outCmd);
    end
    step();                                                          // cycle 4
    checks++;
    if ({outCmd, busy_o, level_o} !== {24'h6_0_0000, 1'b1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL b2b_cyc4 cmd/busy/level got=%h/%b/%0d exp=600000/1/0",
               outCmd, busy_o, level_o);
    end
    step();                                                          // cycle 5
    checks++;
    if ({outCmd, busy_o} !== {NOP_CMD, 1'b0}) begin
      failures++;
      $display("[TB] FAIL b2b_cyc5 cmd/busy got=%h/%b exp=%h/0", outCmd, busy_o, NOP_CMD);
    end
  endtask

  task automatic test_wait_irq();
    push_i = 1'b1; push_wait_i = 1'b1; push_cmd_i = 24'h7_3_1234;   // cycle 0
    step(); push_i = 1'b0; push_wait_i = 1'b0;                       // cycle 1
    step();                                                          // cycle 2: issue
    checks++;
    if (outCmd !== 24'h7_3_1234) begin
      failures++;
      $display("[TB] FAIL wait_issue got=%h exp=731234", outCmd);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 10) interrupt_i = 1'b1;
      checks++;
      if ({outCmd, busy_o} !== {NOP_CMD, 1'b1}) begin
        failures++;
        $display("[TB] FAIL wait_nop_%0d cmd/busy got=%h/%b exp=%h/1", k, outCmd, busy_o, NOP_CMD);
      end
    end
    step();
    checks++;
    if (outCmd !== RDR_CMD) begin
      failures++;
      $display("[TB] FAIL wait_clear got=%h exp=%h", outCmd, RDR_CMD);
    end
    step(); interrupt_i = 1'b0;
    checks++;
    if ({outCmd, busy_o} !== {NOP_CMD, 1'b0}) begin
      failures++;
      $display("[TB] FAIL wait_after_clear cmd/busy got=%h/%b exp=%h/0", outCmd, busy_o, NOP_CMD);
    end
  endtask

  task automatic test_irq_already_high();
    interrupt_i = 1'b1;
    push_i = 1'b1; push_wait_i = 1'b1; push_cmd_i = 24'h7_4_0101;   // cycle 0
    step(); push_i = 1'b0; push_wait_i = 1'b0;
    step();                                                          // cycle 2: issue
    checks++;
    if (outCmd !== 24'h7_4_0101) begin
      failures++;
      $display("[TB] FAIL hi_issue got=%h exp=740101", outCmd);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) interrupt_i = 1'b0;
      if (k == 6) interrupt_i = 1'b1;
      checks++;
      if (outCmd !== NOP_CMD) begin
        failures++;
        $display("[TB] FAIL hi_nop_%0d got=%h exp=%h", k, outCmd, NOP_CMD);
      end
    end
    step();
    checks++;
    if (outCmd !== RDR_CMD) begin
      failures++;
      $display("[TB] FAIL hi_clear got=%h exp=%h", outCmd, RDR_CMD);
    end
    step(); interrupt_i = 1'b0;
    checks++;
    if (outCmd !== NOP_CMD) begin
      failures++;
      $display("[TB] FAIL hi_after_clear got=%h exp=%h", outCmd, NOP_CMD);
    end
  endtask

  task automatic test_timeout();
    push_i = 1'b1; push_wait_i = 1'b1; push_cmd_i = 24'h7_5_0055;   // cycle 0
    step(); push_wait_i = 1'b0; push_cmd_i = 24'h6_1_0001;           // cycle 1
    step(); push_i = 1'b0;                                           // cycle 2: issue
    checks++;
    if (outCmd !== 24'h7_5_0055) begin
      failures++;
      $display("[TB] FAIL tmo_issue got=%h exp=750055", outCmd);
    end
    // Wait cycles 0..63 must stay quiet.
    for (int k = 0; k < 64; k++) begin
      step();
      checks++;
      if ({timeout_o, outCmd} !== {1'b0, NOP_CMD}) begin
        failures++;
        $display("[TB] FAIL tmo_wait_%0d tmo/cmd got=%b/%h exp=0/%h", k, timeout_o, outCmd, NOP_CMD);
      end
    end
    step();                                                          // wait cycle 64
    checks++;
    if ({timeout_o, outCmd, busy_o, level_o} !== {1'b1, NOP_CMD, 1'b1, 3'd1}) begin
      failures++;
      $display("[TB] FAIL tmo_flag tmo/cmd/busy/level got=%b/%h/%b/%0d exp=1/%h/1/1",
               timeout_o, outCmd, busy_o, level_o, NOP_CMD);
    end
    push_i = 1'b1; push_cmd_i = 24'h6_2_0002;
    step(); push_i = 1'b0;
    checks++;
    if (level_o !== 3'd2) begin
      failures++;
      $display("[TB] FAIL tmo_push_in_error level got=%0d exp=2", level_o);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({timeout_o, outCmd} !== {1'b1, NOP_CMD}) begin
        failures++;
        $display("[TB] FAIL tmo_hold_%0d tmo/cmd got=%b/%h exp=1/%h", k, timeout_o, outCmd, NOP_CMD);
      end
    end
    abort_i = 1'b1; push_i = 1'b1; push_cmd_i = 24'h6_3_0003;
    step(); abort_i = 1'b0; push_i = 1'b0;
    checks++;
    if ({timeout_o, busy_o, ready_o, level_o, outCmd} !== {1'b0, 1'b0, 1'b1, 3'd0, NOP_CMD}) begin
      failures++;
      $display("[TB] FAIL tmo_abort tmo/busy/ready/level/cmd got=%b/%b/%b/%0d/%h exp=0/0/1/0/%h",
               timeout_o, busy_o, ready_o, level_o, outCmd, NOP_CMD);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (outCmd !== NOP_CMD) begin
        failures++;
        $display("[TB] FAIL tmo_after_abort_%0d got=%h exp=%h", k, outCmd, NOP_CMD);
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] exp;
    push_i = 1'b1; push_wait_i = 1'b1; push_cmd_i = 24'h7_6_0066;   // cycle 0
    step(); push_i = 1'b0; push_wait_i = 1'b0;
    step();                                                          // cycle 2: issue
    checks++;
    if (outCmd !== 24'h7_6_0066) begin
      failures++;
      $display("[TB] FAIL ovf_issue got=%h exp=760066", outCmd);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      push_i = 1'b1;
      push_cmd_i = {4'h8, 4'(i), 16'(i)};
    end
    checks++;
    if ({ready_o, overflow_o, level_o} !== {1'b0, 1'b0, 3'd4}) begin
      failures++;
      $display("[TB] FAIL ovf_full_before ready/ovf/level got=%b/%b/%0d exp=0/0/4",
               ready_o, overflow_o, level_o);
    end
    step(); push_i = 1'b0;
    checks++;
    if ({ready_o, overflow_o, level_o, outCmd} !== {1'b0, 1'b1, 3'd4, NOP_CMD}) begin
      failures++;
      $display("[TB] FAIL ovf_flag ready/ovf/level/cmd got=%b/%b/%0d/%h exp=0/1/4/%h",
               ready_o, overflow_o, level_o, outCmd, NOP_CMD);
    end
    interrupt_i = 1'b1;
    step(); interrupt_i = 1'b0;
    checks++;
    if (outCmd !== RDR_CMD) begin
      failures++;
      $display("[TB] FAIL ovf_clear got=%h exp=%h", outCmd, RDR_CMD);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = {4'h8, 4'(i), 16'(i)};
      checks++;
      if (outCmd !== exp) begin
        failures++;
        $display("[TB] FAIL ovf_drain_%0d got=%h exp=%h", i, outCmd, exp);
      end
    end
    step();
    checks++;
    if ({outCmd, overflow_o, level_o} !== {NOP_CMD, 1'b1, 3'd0}) begin
      failures++;
      $display("[TB] FAIL ovf_fifth_dropped cmd/ovf/level got=%h/%b/%0d exp=%h/1/0",
               outCmd, overflow_o, level_o, NOP_CMD);
    end
    abort_i = 1'b1;
    step(); abort_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_abort_clears got=%b exp=0", overflow_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    push_i = 1'b1; push_wait_i = 1'b1; push_cmd_i = 24'h7_7_0077;   // cycle 0
    for (int i = 1; i <= 3; i++) begin
      step();
      push_wait_i = 1'b0;
      push_cmd_i  = {4'h9, 4'h0, 16'(i)};
      if (i == 2) begin
        checks++;
        if (outCmd !== 24'h7_7_0077) begin
          failures++;
          $display("[TB] FAIL rst_wait_issue got=%h exp=770077", outCmd);
        end
      end
    end
    step(); push_i = 1'b0;                                           // cycle 4
    checks++;
    if ({level_o, busy_o, outCmd} !== {3'd3, 1'b1, NOP_CMD}) begin
      failures++;
      $display("[TB] FAIL rst_wait_pre level/busy/cmd got=%0d/%b/%h exp=3/1/%h",
               level_o, busy_o, outCmd, NOP_CMD);
    end
    interrupt_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({outCmd, level_o, busy_o, ready_o} !== {NOP_CMD, 3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL rst_wait_async cmd/level/busy/ready got=%h/%0d/%b/%b exp=%h/0/0/1",
               outCmd, level_o, busy_o, ready_o, NOP_CMD);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      interrupt_i = ~interrupt_i;
      checks++;
      if ({outCmd, busy_o} !== {NOP_CMD, 1'b0}) begin
        failures++;
        $display("[TB] FAIL rst_wait_no_clear_%0d cmd/busy got=%h/%b exp=%h/0",
                 k, outCmd, busy_o, NOP_CMD);
      end
    end
    interrupt_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_irq();
    test_irq_already_high();
    test_timeout();
    test_overflow();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/aether_cmd_sequencer.md
AETHER_CMD_SEQUENCER -- requirements
Module: aether_cmd_sequencer

Interface
REQ-001 SHALL have parameter InstrWidth, default 4, opcode field width.
REQ-002 SHALL have parameter Param1Width, default 4, param_1 field width.
REQ-003 SHALL have parameter Param2Width, default 16, param_2 field width.
REQ-004 SHALL have parameter Depth, default 16 (power of two, >=2), command queue entries.
REQ-005 SHALL have parameter TimeoutCycles, default 1_048_576, max cycles spent waiting for interrupt.
REQ-006 SHALL have port clk_i  input  1  single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port push_i  input  1  enqueue request.
REQ-009 SHALL have port push_cmd_i  input  InstrWidth+Param1Width+Param2Width  command word {instr, param_1, param_2}.
REQ-010 SHALL have port push_wait_i  input  1  after issuing, wait for engine interrupt, then clear it.
REQ-011 SHALL have port ready_o  output  1  queue not full.
REQ-012 SHALL have port abort_i  input  1  flush queue, clear error, return to IDLE.
REQ-013 SHALL have port interrupt_i  input  1  engine interrupt.
REQ-014 SHALL have ports instruction_o / param_1_o / param_2_o  output  InstrWidth / Param1Width / Param2Width  registered engine command.
REQ-015 SHALL have port busy_o  output  1  state not IDLE or queue non-empty.
REQ-016 SHALL have port level_o  output  $clog2(Depth)+1  queue occupancy.
REQ-017 SHALL have ports overflow_o, timeout_o  output  1 each  sticky error flags.

Function
REQ-018 SHALL drive {NOP, 0, 0} on the command outputs every cycle no command or clear is being issued.
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_IRQ, CLEAR, ERROR.
REQ-020 SHALL accept push_i only when ready_o=1; push while full is dropped and sets overflow_o.
REQ-021 SHALL make a push in cycle N into an empty queue in IDLE appear on the outputs in cycle N+2.
REQ-022 SHALL issue non-wait entries back-to-back, one per cycle, each held exactly one cycle.
REQ-023 SHALL, after issuing a wait entry, enter WAIT_IRQ, output NOP, and pop nothing further.
REQ-024 SHALL detect interrupt as a rising edge (interrupt_i=1, previous cycle 0), sampled from the cycle after issue.
REQ-025 SHALL, on the edge, go to CLEAR and output {RDR, REG_STATS, 0} for exactly one cycle, then resume (IDLE or next entry).
REQ-026 SHALL, when interrupt_i is already high at wait entry, require it to fall and rise again.
REQ-027 SHALL count WAIT_IRQ cycles from 0; on reaching TimeoutCycles it sets timeout_o, enters ERROR, outputs NOP, stops popping.
REQ-028 SHALL hold ERROR until abort_i; queued entries are retained and pushes accepted.
REQ-029 SHALL, on abort_i in any state, empty the queue, clear overflow_o/timeout_o, go to IDLE, and output NOP next cycle; a simultaneous push is dropped.
REQ-030 SHALL allow push and pop in the same cycle, with level_o unchanged.
REQ-031 SHALL wrap queue pointers modulo Depth; level_o ranges 0..Depth.

Reset
REQ-032 SHALL, on rst_ni low, asynchronously reach: state IDLE, queue empty, level_o=0, ready_o=1, busy_o=0, flags 0, outputs {NOP,0,0}, edge register 0, timeout counter 0.
REQ-033 SHALL, on reset mid-wait, discard the pending wait and never issue the CLEAR command.

Structure
REQ-034 SHALL take opcodes (NOP, RDR), register address REG_STATS, and field widths from the shared aether constants package.
REQ-035 SHALL place the state enum typedef in that shared package.
REQ-036 SHALL implement the queue as sub-module aether_cmd_fifo (Depth x (command width+1), full/empty/level).

Verification
REQ-037 SHALL cover: push three non-wait commands 24'h5_1_0040, 24'h5_2_0004, 24'h6_0_0000 in cycles 0-2 -> outputs in cycles 2,3,4, then NOP.
REQ-038 SHALL cover: push wait command; interrupt rises 10 cycles after issue -> NOP for 10 cycles, one RDR/REG_STATS cycle, then IDLE.
REQ-039 SHALL cover: TimeoutCycles=64, wait command, interrupt held low -> timeout_o=1 at wait cycle 64; the following entry is not issued until abort_i.
REQ-040 SHALL cover: Depth=4, five pushes with no pops (stalled in WAIT_IRQ) -> level_o=4, ready_o=0, overflow_o=1, fifth dropped.
REQ-041 SHALL cover: rst_ni low during WAIT_IRQ with 3 queued entries -> outputs NOP immediately, level_o=0, no clear issued.
REQ-042 SHALL cover: interrupt_i high when wait begins, fall at +3, rise at +6 -> CLEAR only after the rise at +6.
